// File: rtl/life_gen_scheduler_if.sv
// Signal bundle between life_gen_scheduler and its neighbours: the register
// file (control pulses), the host loader, the next-state engine and the
// stream packer (frame_done).
// Optional build macro: AUTO_STOP_EN (adds stop_gen).
interface life_gen_scheduler_if #(
    parameter int ROW_AW = 10,
    parameter int DIV_W  = 8
);
    logic              init_start;
    logic              init_row_valid;
    logic              init_row_ready;
    logic              pause;
    logic              step;
    logic              frame_done;
    logic [DIV_W-1:0]  gen_div;
    logic              calc_row_req;
    logic [ROW_AW-1:0] calc_row_addr;
    logic              calc_row_ack;
    logic              wr_en;
    logic [ROW_AW-1:0] wr_addr;
    logic              front_sel;
    logic [15:0]       gen_count;
    logic              busy;
`ifdef AUTO_STOP_EN
    logic [15:0]       stop_gen;
`endif

    // Scheduler side.
    modport slave (
`ifdef AUTO_STOP_EN
        input  stop_gen,
`endif
        input  init_start,
        input  init_row_valid,
        input  pause,
        input  step,
        input  frame_done,
        input  gen_div,
        input  calc_row_ack,
        output init_row_ready,
        output calc_row_req,
        output calc_row_addr,
        output wr_en,
        output wr_addr,
        output front_sel,
        output gen_count,
        output busy
    );

    // Host / engine / display side.
    modport master (
`ifdef AUTO_STOP_EN
        output stop_gen,
`endif
        output init_start,
        output init_row_valid,
        output pause,
        output step,
        output frame_done,
        output gen_div,
        output calc_row_ack,
        input  init_row_ready,
        input  calc_row_req,
        input  calc_row_addr,
        input  wr_en,
        input  wr_addr,
        input  front_sel,
        input  gen_count,
        input  busy
    );
endinterface

// File: rtl/life_gen_scheduler.sv
// Ping-pong row-buffer scheduler for the Game-of-Life pixel generator.
// Handles host grid load, row-by-row dispatch to the next-state engine and
// buffer swaps that only happen on display frame boundaries.
// Optional build macro: AUTO_STOP_EN (HOLD pauses once gen_count == stop_gen).
module life_gen_scheduler #(
    parameter int ROWS   = 720,
    parameter int ROW_AW = 10,
    parameter int DIV_W  = 8
) (
    input  logic                 out_stream_aclk,
    input  logic                 periph_reset,
    life_gen_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SWAP_WAIT,
        ST_HOLD,
        ST_COMPUTE
    } state_t;

    localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);
    localparam logic [DIV_W-1:0]  CNT_MAX  = '1;

    state_t             r_state;
    logic [ROW_AW-1:0]  r_row;
    logic [DIV_W-1:0]   r_frame_cnt;
    logic               r_load_flag;
    logic               r_front_sel;
    logic [15:0]        r_gen_count;
    logic               r_init_row_ready;
    logic               r_calc_row_req;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [ROW_AW-1:0]  w_row_nxt;
    logic [DIV_W-1:0]   w_frame_cnt_nxt;
    logic               w_load_flag_nxt;
    logic               w_front_sel_nxt;
    logic [15:0]        w_gen_count_nxt;

    logic [DIV_W-1:0]   w_gen_div_eff;
    logic [DIV_W:0]     w_cnt_inc;
    logic [DIV_W-1:0]   w_cnt_sat;
    logic               w_swap_hit;
    logic               w_wr_accept;
    logic               w_row_ack;
    logic               w_auto_stop;
    logic               w_hold_paused;

    // A divider of 0 behaves as 1; compare against counter+1 one bit wider.
    assign w_gen_div_eff = (bus.gen_div == '0) ? DIV_W'(1) : bus.gen_div;
    assign w_cnt_inc     = {1'b0, r_frame_cnt} + (DIV_W+1)'(1);
    assign w_cnt_sat     = (r_frame_cnt == CNT_MAX) ? r_frame_cnt : r_frame_cnt + DIV_W'(1);
    // The first frame after a load always swaps so the loaded grid shows at once.
    assign w_swap_hit    = r_load_flag || (w_cnt_inc >= {1'b0, w_gen_div_eff});
    assign w_wr_accept   = bus.init_row_valid & r_init_row_ready;
    assign w_row_ack     = r_calc_row_req & bus.calc_row_ack;

`ifdef AUTO_STOP_EN
    assign w_auto_stop   = (bus.stop_gen != 16'd0) && (r_gen_count == bus.stop_gen);
`else
    assign w_auto_stop   = 1'b0;
`endif
    assign w_hold_paused = bus.pause | w_auto_stop;

    // Next-state and next-datapath decode.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned, which would infer a latch.
        w_state_nxt     = r_state;
        w_row_nxt       = r_row;
        w_frame_cnt_nxt = r_frame_cnt;
        w_load_flag_nxt = r_load_flag;
        w_front_sel_nxt = r_front_sel;
        w_gen_count_nxt = r_gen_count;

        // Frames keep counting toward the next swap in every post-load state.
        if (bus.frame_done && (r_state inside {ST_SWAP_WAIT, ST_HOLD, ST_COMPUTE})) begin
            w_frame_cnt_nxt = w_cnt_sat;
        end

        unique case (r_state)
            ST_IDLE: begin
                // Only init_start (handled below) leaves IDLE.
            end
            ST_LOAD: begin
                if (w_wr_accept) begin
                    if (r_row == LAST_ROW) begin
                        w_row_nxt       = '0;
                        w_load_flag_nxt = 1'b1;
                        w_state_nxt     = ST_SWAP_WAIT;
                    end else begin
                        w_row_nxt = r_row + ROW_AW'(1);
                    end
                end
            end
            ST_SWAP_WAIT: begin
                if (bus.frame_done && w_swap_hit) begin
                    w_front_sel_nxt = ~r_front_sel;
                    w_frame_cnt_nxt = '0;
                    w_load_flag_nxt = 1'b0;
                    if (!r_load_flag) begin
                        w_gen_count_nxt = r_gen_count + 16'd1;
                    end
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!w_hold_paused || bus.step) begin
                    w_state_nxt = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (w_row_ack) begin
                    if (r_row == LAST_ROW) begin
                        w_row_nxt   = '0;
                        w_state_nxt = ST_SWAP_WAIT;
                    end else begin
                        w_row_nxt = r_row + ROW_AW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A load request overrides everything, including a same-cycle swap.
        if (bus.init_start) begin
            w_state_nxt     = ST_LOAD;
            w_row_nxt       = '0;
            w_frame_cnt_nxt = '0;
            w_load_flag_nxt = 1'b0;
            w_front_sel_nxt = r_front_sel;
            w_gen_count_nxt = 16'd0;
        end
    end

    // State, datapath and registered-output update with synchronous reset.
    always_ff @(posedge out_stream_aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (periph_reset) begin
            r_state          <= ST_IDLE;
            r_row            <= '0;
            r_frame_cnt      <= '0;
            r_load_flag      <= 1'b0;
            r_front_sel      <= 1'b0;
            r_gen_count      <= 16'd0;
            r_init_row_ready <= 1'b0;
            r_calc_row_req   <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_row            <= w_row_nxt;
            r_frame_cnt      <= w_frame_cnt_nxt;
            r_load_flag      <= w_load_flag_nxt;
            r_front_sel      <= w_front_sel_nxt;
            r_gen_count      <= w_gen_count_nxt;
            r_init_row_ready <= (w_state_nxt == ST_LOAD);
            r_calc_row_req   <= (w_state_nxt == ST_COMPUTE);
            r_busy           <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_COMPUTE);
        end
    end

    assign bus.init_row_ready = r_init_row_ready;
    assign bus.calc_row_req   = r_calc_row_req;
    assign bus.calc_row_addr  = r_row;
    assign bus.wr_en          = w_wr_accept;
    assign bus.wr_addr        = r_row;
    assign bus.front_sel      = r_front_sel;
    assign bus.gen_count      = r_gen_count;
    assign bus.busy           = r_busy;

endmodule
